// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and constants for the register-file dumper.
// Holds the FSM state encoding, checksum width and byte-count helpers.
package regdump_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
    localparam int unsigned CSUM_WIDTH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_DONE  = 3'd3,
        ST_CSUM  = 3'd4
    } state_t;

    // Bytes carried by one register word of the given width
    function automatic int unsigned bytes_per_word(input int unsigned dw);
        return dw / 8;
    endfunction

    // Counter width able to index n items (never zero)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dumper_if.sv
// regfile_dumper_if: groups the register-file read port, the byte stream
// and the start/busy/done status of the dumper.
//   slave  : dumper side  (in: Start, ReadData, Ready; out: ReadRegister,
//            DataOut, Valid, Busy, Done)
//   master : environment side (directions mirrored)
interface regfile_dumper_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  Start;
    logic [ADDR_WIDTH-1:0] ReadRegister;
    logic [DATA_WIDTH-1:0] ReadData;
    logic [7:0]            DataOut;
    logic                  Valid;
    logic                  Ready;
    logic                  Busy;
    logic                  Done;

    modport slave (
        input  Start, ReadData, Ready,
        output ReadRegister, DataOut, Valid, Busy, Done
    );

    modport master (
        output Start, ReadData, Ready,
        input  ReadRegister, DataOut, Valid, Busy, Done
    );
endinterface

// File: rtl/regdump_serializer.sv
// regdump_serializer: latches one register word and streams it out LSB byte
// first over a valid/ready handshake; can also present a single stand-alone
// byte (used for the trailing checksum).
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_load_word       latch i_word, restart at byte 0, raise valid
//   i_load_byte       present i_byte as a single last byte, raise valid
//   i_ready           downstream ready
//   o_data, o_valid   stream byte and its valid
//   o_fire_c          handshake this cycle (combinational)
//   o_last_c          current byte is the last of the word (combinational)
module regdump_serializer
    import regdump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_word,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_load_byte,
    input  logic [7:0]            i_byte,
    input  logic                  i_ready,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    output logic                  o_fire_c,
    output logic                  o_last_c
);
    localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
    localparam int unsigned CNT_W = cnt_width(BPW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;

    assign o_fire_c = r_valid & i_ready;
    assign o_last_c = (r_cnt == LAST_CNT);

    // Word latch / shift register; the low byte is always the byte on offer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load_word) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (i_load_byte) begin
            // Stand-alone byte is marked last so one handshake retires it
            r_shift <= DATA_WIDTH'(i_byte);
            r_cnt   <= LAST_CNT;
            r_valid <= 1'b1;
        end else if (o_fire_c) begin
            r_shift <= r_shift >> 8;
            if (o_last_c) begin
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_data  = r_shift[7:0];
    assign o_valid = r_valid;

endmodule

// File: rtl/regfile_dumper.sv
// regfile_dumper: on Start, walks register addresses 0..NUM_REGS-1 through
// the register-file read port and streams each word LSB byte first.
// Optional macro REGDUMP_CHECKSUM_EN appends one XOR checksum byte.
// Ports:
//   Clk, Reset   clock, async active-high reset
//   bus (slave)  Start/Busy/Done status, ReadRegister/ReadData read port,
//                DataOut/Valid/Ready byte stream
module regfile_dumper
    import regdump_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    regfile_dumper_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load_word;
    logic                  w_load_byte;
    logic                  w_idx_clr;
    logic                  w_idx_inc;
    logic                  w_fire;
    logic                  w_last;
    logic                  w_valid;
    logic [7:0]            w_data;
    logic [7:0]            w_csum_byte;

    regdump_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_load_word (w_load_word),
        .i_word      (bus.ReadData),
        .i_load_byte (w_load_byte),
        .i_byte      (w_csum_byte),
        .i_ready     (bus.Ready),
        .o_data      (w_data),
        .o_valid     (w_valid),
        .o_fire_c    (w_fire),
        .o_last_c    (w_last)
    );

    // Next-state and control decode
    always_comb begin
        w_next      = r_state;
        w_load_word = 1'b0;
        w_load_byte = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
                    w_next    = ST_FETCH;
                    w_idx_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                w_load_word = 1'b1;
                w_next      = ST_SEND;
            end
            ST_SEND: begin
                if (w_fire && w_last) begin
                    if (r_idx < LAST_IDX) begin
                        w_idx_inc = 1'b1;
                        w_next    = ST_FETCH;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_load_byte = 1'b1;
                        w_next      = ST_CSUM;
`else
                        w_next      = ST_DONE;
`endif
                    end
                end
            end
            ST_CSUM: begin
                if (w_fire) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, index and status registers; Busy/Done follow the next state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [CSUM_WIDTH-1:0] r_csum;
    logic [CSUM_WIDTH-1:0] w_csum_next;

    // Includes the byte being accepted so the last data byte is counted
    assign w_csum_next = r_csum ^ w_data;

    // Running XOR over accepted data bytes only
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_csum <= '0;
        end else if (w_idx_clr) begin
            r_csum <= '0;
        end else if ((r_state == ST_SEND) && w_fire) begin
            r_csum <= w_csum_next;
        end
    end

    assign w_csum_byte = w_csum_next;
`else
    assign w_csum_byte = '0;
`endif

    assign bus.ReadRegister = r_idx;
    assign bus.DataOut      = w_data;
    assign bus.Valid        = w_valid;
    assign bus.Busy         = r_busy;
    assign bus.Done         = r_done;

endmodule
